// File: rtl/ps2_scancode_rx.sv
// PS/2 device-to-host receiver: filters ps2_clk, deserialises 11-bit frames and decodes E0/F0 prefixes into a held scancode.
// Latency: outputs update one clk after the stop-bit tick. No backpressure: strobes are single-cycle and unbuffered.
module ps2_scancode_rx #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 5000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] scancode,
  output logic       extended,
  output logic       key_valid,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  state_t          state;
  state_t          state_nxt;

  logic            clk_s1;
  logic            clk_s2;
  logic            dat_s1;
  logic            dat_s2;
  logic            clk_filt;
  logic            clk_filt_d;
  logic [FW-1:0]   filt_cnt;
  logic            tick;

  logic [2:0]      bitcnt;
  logic [7:0]      shreg;
  logic            par_bit;
  logic [TW-1:0]   wdog;
  logic            timeout;

  logic            stop_tick;
  logic            frame_ok;
  logic            byte_vld;
  logic            frame_bad;
  logic            shift_en;
  logic            par_en;

  logic            ext_pend;
  logic            brk_pend;

  // Idle-high lines: synchronisers come out of reset at 1 so no false start edge is seen.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_data;
      dat_s2 <= dat_s1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_filt   <= 1'b1;
      clk_filt_d <= 1'b1;
      filt_cnt   <= '0;
    end else begin
      clk_filt_d <= clk_filt;
      if (clk_s2 == clk_filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
        clk_filt <= clk_s2;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  assign tick = clk_filt_d & ~clk_filt;

  // A tick landing on the expiry cycle keeps the frame alive.
  assign timeout = (state != IDLE) && (wdog == TW'(TIMEOUT - 1)) && !tick;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (timeout) begin
      state_nxt = IDLE;
    end else if (tick) begin
      case (state)
        IDLE:    state_nxt = dat_s2 ? IDLE : DATA;
        DATA:    state_nxt = (bitcnt == 3'd7) ? PARITY : DATA;
        PARITY:  state_nxt = STOP;
        STOP:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    stop_tick = (state == STOP) && tick;
    frame_ok  = dat_s2 && (^{shreg, par_bit});
    byte_vld  = stop_tick && frame_ok;
    frame_bad = (stop_tick && !frame_ok) || timeout;
    shift_en  = (state == DATA) && tick;
    par_en    = (state == PARITY) && tick;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bitcnt  <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
      wdog    <= '0;
    end else begin
      if (timeout || state == IDLE) begin
        bitcnt <= '0;
      end else if (shift_en) begin
        bitcnt <= bitcnt + 1'b1;
      end

      // LSB arrives first, so each new bit enters at the top.
      if (shift_en) begin
        shreg <= {dat_s2, shreg[7:1]};
      end

      if (par_en) begin
        par_bit <= dat_s2;
      end

      if (tick || timeout || state == IDLE) begin
        wdog <= '0;
      end else begin
        wdog <= wdog + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scancode  <= '0;
      extended  <= 1'b0;
      key_valid <= 1'b0;
      frame_err <= 1'b0;
      ext_pend  <= 1'b0;
      brk_pend  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      frame_err <= frame_bad;
      if (byte_vld) begin
        if (shreg == 8'hE0) begin
          ext_pend <= 1'b1;
        end else if (shreg == 8'hF0) begin
          brk_pend <= 1'b1;
        end else if (brk_pend) begin
          // Breaks for keys other than the held one are dropped silently.
          if (shreg == scancode && ext_pend == extended) begin
            scancode <= 8'h00;
            extended <= 1'b0;
          end
          ext_pend <= 1'b0;
          brk_pend <= 1'b0;
        end else begin
          scancode  <= shreg;
          extended  <= ext_pend;
          key_valid <= 1'b1;
          ext_pend  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Bench for ps2_scancode_rx: drives PS/2 frames on the pins and compares against a byte-level decode model.
module tb_ps2_scancode_rx;

  localparam int FILTER_LEN = 8;
  localparam int TIMEOUT    = 5000;

  logic       clk      = 1'b0;
  logic       reset    = 1'b0;
  logic       ps2_clk  = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] scancode;
  logic       extended;
  logic       key_valid;
  logic       frame_err;

  ps2_scancode_rx #(
    .FILTER_LEN(FILTER_LEN),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .scancode (scancode),
    .extended (extended),
    .key_valid(key_valid),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int kv_cnt = 0;
  int fe_cnt = 0;
  int wide_cnt = 0;
  int last_kv_cyc = 0;
  int last_fall_cyc = 0;
  logic kv_prev = 1'b0;
  logic fe_prev = 1'b0;

  logic [7:0] m_sc = 8'h00;
  logic       m_ext = 1'b0;
  logic       m_ep = 1'b0;
  logic       m_bp = 1'b0;
  int         exp_kv = 0;
  int         exp_fe = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (key_valid) begin
      kv_cnt++;
      last_kv_cyc = cyc;
      if (kv_prev) wide_cnt++;
    end
    if (frame_err) begin
      fe_cnt++;
      if (fe_prev) wide_cnt++;
    end
    kv_prev = key_valid;
    fe_prev = frame_err;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Device-side PS/2 waveform: data changes mid-high, host samples on the falling edge.
  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = bits[i];
      idle(15);
      ps2_clk = 1'b0;
      last_fall_cyc = cyc;
      idle(30);
      ps2_clk = 1'b1;
      idle(15);
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (b == 8'hE0) begin
      m_ep = 1'b1;
    end else if (b == 8'hF0) begin
      m_bp = 1'b1;
    end else if (m_bp) begin
      if (b == m_sc && m_ep == m_ext) begin
        m_sc  = 8'h00;
        m_ext = 1'b0;
      end
      m_ep = 1'b0;
      m_bp = 1'b0;
    end else begin
      m_sc  = b;
      m_ext = m_ep;
      m_ep  = 1'b0;
      exp_kv++;
    end
  endtask

  task automatic xfer(input logic [7:0] d, input bit bad_par, input bit bad_stop);
    logic par;
    logic stp;
    par = (~^d) ^ bad_par;
    stp = ~bad_stop;
    send_bits({stp, par, d, 1'b0}, 11);
    ps2_data = 1'b1;
    idle(20);
    if (!bad_par && !bad_stop) model_byte(d);
    else exp_fe++;
  endtask

  task automatic test_reset;
    idle(4);
    n_cmp++; if (scancode !== 8'h00) begin n_fail++; $display("FAIL reset_sc: got %h want 00", scancode); end
    n_cmp++; if (extended !== 1'b0) begin n_fail++; $display("FAIL reset_ext: got %b want 0", extended); end
    n_cmp++; if (key_valid !== 1'b0) begin n_fail++; $display("FAIL reset_kv: got %b want 0", key_valid); end
    n_cmp++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_fe: got %b want 0", frame_err); end
    reset = 1'b1;
    idle(10);
  endtask

  task automatic test_make;
    int lat;
    xfer(8'h2B, 1'b0, 1'b0);
    lat = last_kv_cyc - last_fall_cyc;
    n_cmp++; if (scancode !== m_sc) begin n_fail++; $display("FAIL make_sc: got %h want %h", scancode, m_sc); end
    n_cmp++; if (extended !== m_ext) begin n_fail++; $display("FAIL make_ext: got %b want %b", extended, m_ext); end
    n_cmp++; if (kv_cnt !== exp_kv) begin n_fail++; $display("FAIL make_kv: got %0d want %0d", kv_cnt, exp_kv); end
    n_cmp++; if (fe_cnt !== exp_fe) begin n_fail++; $display("FAIL make_fe: got %0d want %0d", fe_cnt, exp_fe); end
    n_cmp++; if (wide_cnt !== 0) begin n_fail++; $display("FAIL make_width: got %0d wide strobes want 0", wide_cnt); end
    n_cmp++; if (lat < FILTER_LEN + 2 || lat > FILTER_LEN + 4) begin
      n_fail++; $display("FAIL make_latency: got %0d cycles want %0d..%0d", lat, FILTER_LEN + 2, FILTER_LEN + 4);
    end
  endtask

  task automatic test_typematic;
    for (int i = 0; i < 3; i++) xfer(8'h2B, 1'b0, 1'b0);
    n_cmp++; if (scancode !== m_sc) begin n_fail++; $display("FAIL typematic_sc: got %h want %h", scancode, m_sc); end
    n_cmp++; if (kv_cnt !== exp_kv) begin n_fail++; $display("FAIL typematic_kv: got %0d want %0d", kv_cnt, exp_kv); end
  endtask

  task automatic test_release;
    xfer(8'hF0, 1'b0, 1'b0);
    xfer(8'h2B, 1'b0, 1'b0);
    n_cmp++; if (scancode !== m_sc) begin n_fail++; $display("FAIL release_sc: got %h want %h", scancode, m_sc); end
    n_cmp++; if (kv_cnt !== exp_kv) begin n_fail++; $display("FAIL release_kv: got %0d want %0d", kv_cnt, exp_kv); end
    xfer(8'h1C, 1'b0, 1'b0);
    xfer(8'hF0, 1'b0, 1'b0);
    xfer(8'h15, 1'b0, 1'b0);
    n_cmp++; if (scancode !== m_sc) begin n_fail++; $display("FAIL release_other_sc: got %h want %h", scancode, m_sc); end
    n_cmp++; if (kv_cnt !== exp_kv) begin n_fail++; $display("FAIL release_other_kv: got %0d want %0d", kv_cnt, exp_kv); end
  endtask

  task automatic test_extended;
    xfer(8'hE0, 1'b0, 1'b0);
    xfer(8'h75, 1'b0, 1'b0);
    n_cmp++; if (scancode !== m_sc) begin n_fail++; $display("FAIL ext_make_sc: got %h want %h", scancode, m_sc); end
    n_cmp++; if (extended !== m_ext) begin n_fail++; $display("FAIL ext_make_ext: got %b want %b", extended, m_ext); end
    n_cmp++; if (kv_cnt !== exp_kv) begin n_fail++; $display("FAIL ext_make_kv: got %0d want %0d", kv_cnt, exp_kv); end
    // Non-extended break of the same code must not release the extended key.
    xfer(8'hF0, 1'b0, 1'b0);
    xfer(8'h75, 1'b0, 1'b0);
    n_cmp++; if (scancode !== m_sc) begin n_fail++; $display("FAIL ext_plainbrk_sc: got %h want %h", scancode, m_sc); end
    xfer(8'hE0, 1'b0, 1'b0);
    xfer(8'hF0, 1'b0, 1'b0);
    xfer(8'h75, 1'b0, 1'b0);
    n_cmp++; if (scancode !== m_sc) begin n_fail++; $display("FAIL ext_brk_sc: got %h want %h", scancode, m_sc); end
    n_cmp++; if (extended !== m_ext) begin n_fail++; $display("FAIL ext_brk_ext: got %b want %b", extended, m_ext); end
  endtask

  task automatic test_errors;
    xfer(8'h1C, 1'b0, 1'b0);
    xfer(8'h15, 1'b1, 1'b0);
    n_cmp++; if (fe_cnt !== exp_fe) begin n_fail++; $display("FAIL parity_fe: got %0d want %0d", fe_cnt, exp_fe); end
    n_cmp++; if (scancode !== m_sc) begin n_fail++; $display("FAIL parity_sc: got %h want %h", scancode, m_sc); end
    n_cmp++; if (kv_cnt !== exp_kv) begin n_fail++; $display("FAIL parity_kv: got %0d want %0d", kv_cnt, exp_kv); end
    xfer(8'h22, 1'b0, 1'b1);
    n_cmp++; if (fe_cnt !== exp_fe) begin n_fail++; $display("FAIL stop_fe: got %0d want %0d", fe_cnt, exp_fe); end
    n_cmp++; if (scancode !== m_sc) begin n_fail++; $display("FAIL stop_sc: got %h want %h", scancode, m_sc); end
    n_cmp++; if (wide_cnt !== 0) begin n_fail++; $display("FAIL err_width: got %0d wide strobes want 0", wide_cnt); end
  endtask

  task automatic test_timeout;
    send_bits({2'b11, 8'h0D, 1'b0}, 6);
    ps2_data = 1'b1;
    idle(TIMEOUT + 10);
    exp_fe++;
    n_cmp++; if (fe_cnt !== exp_fe) begin n_fail++; $display("FAIL timeout_fe: got %0d want %0d", fe_cnt, exp_fe); end
    n_cmp++; if (scancode !== m_sc) begin n_fail++; $display("FAIL timeout_sc: got %h want %h", scancode, m_sc); end
    xfer(8'h22, 1'b0, 1'b0);
    n_cmp++; if (scancode !== m_sc) begin n_fail++; $display("FAIL timeout_next_sc: got %h want %h", scancode, m_sc); end
    n_cmp++; if (fe_cnt !== exp_fe) begin n_fail++; $display("FAIL timeout_next_fe: got %0d want %0d", fe_cnt, exp_fe); end
  endtask

  task automatic test_glitch;
    // Data held low so a spurious tick would be taken as a start bit and misalign the next frame.
    ps2_data = 1'b0;
    idle(2);
    ps2_clk = 1'b0;
    idle(FILTER_LEN - 2);
    ps2_clk = 1'b1;
    idle(2);
    ps2_data = 1'b1;
    idle(30);
    n_cmp++; if (fe_cnt !== exp_fe) begin n_fail++; $display("FAIL glitch_fe: got %0d want %0d", fe_cnt, exp_fe); end
    xfer(8'h1C, 1'b0, 1'b0);
    n_cmp++; if (scancode !== m_sc) begin n_fail++; $display("FAIL glitch_sc: got %h want %h", scancode, m_sc); end
    n_cmp++; if (kv_cnt !== exp_kv) begin n_fail++; $display("FAIL glitch_kv: got %0d want %0d", kv_cnt, exp_kv); end
  endtask

  task automatic test_reset_midframe;
    xfer(8'hE0, 1'b0, 1'b0);
    send_bits({2'b11, 8'h4D, 1'b0}, 5);
    reset = 1'b0;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    idle(3);
    m_sc = 8'h00; m_ext = 1'b0; m_ep = 1'b0; m_bp = 1'b0;
    n_cmp++; if (scancode !== m_sc) begin n_fail++; $display("FAIL midreset_sc: got %h want %h", scancode, m_sc); end
    reset = 1'b1;
    idle(10);
    xfer(8'h33, 1'b0, 1'b0);
    n_cmp++; if (scancode !== m_sc) begin n_fail++; $display("FAIL midreset_next_sc: got %h want %h", scancode, m_sc); end
    n_cmp++; if (extended !== m_ext) begin n_fail++; $display("FAIL midreset_next_ext: got %b want %b", extended, m_ext); end
    n_cmp++; if (kv_cnt !== exp_kv) begin n_fail++; $display("FAIL midreset_next_kv: got %0d want %0d", kv_cnt, exp_kv); end
  endtask

  task automatic test_random;
    logic [7:0] b;
    int         sel;
    int         err;
    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 9);
      err = $urandom_range(0, 11);
      if (sel < 2)      b = 8'hE0;
      else if (sel < 4) b = 8'hF0;
      else if (sel < 6) b = m_sc;
      else              b = 8'($urandom_range(0, 255));
      xfer(b, err == 0, err == 1);
      n_cmp++; if (scancode !== m_sc) begin n_fail++; $display("FAIL rand_sc[%0d]: byte %h got %h want %h", i, b, scancode, m_sc); end
      n_cmp++; if (extended !== m_ext) begin n_fail++; $display("FAIL rand_ext[%0d]: got %b want %b", i, extended, m_ext); end
      n_cmp++; if (kv_cnt !== exp_kv) begin n_fail++; $display("FAIL rand_kv[%0d]: got %0d want %0d", i, kv_cnt, exp_kv); end
      n_cmp++; if (fe_cnt !== exp_fe) begin n_fail++; $display("FAIL rand_fe[%0d]: got %0d want %0d", i, fe_cnt, exp_fe); end
    end
    n_cmp++; if (wide_cnt !== 0) begin n_fail++; $display("FAIL rand_width: got %0d wide strobes want 0", wide_cnt); end
  endtask

  initial begin
    test_reset();
    test_make();
    test_typematic();
    test_release();
    test_extended();
    test_errors();
    test_timeout();
    test_glitch();
    test_reset_midframe();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
